// File: rtl/trace_fifo_pkg.sv
// Shared types and defaults for the retired-instruction trace FIFO.
// Optional feature macro: TRACE_FILTER_EN (capture only register-writing instructions).
package mips_trace_pkg;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_CNT_W = 16;
    // Entries carry a fixed-width seq field; CNT_W up to this width is supported.
    localparam int SEQ_MAX_W     = 32;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [31:0]          result;
        logic                 wr;
        logic [SEQ_MAX_W-1:0] seq;
    } trace_entry_t;
endpackage

// File: rtl/trace_fifo_if.sv
// Capture and drain handshake bundle for trace_fifo.
interface trace_fifo_if #(parameter int CNT_W = mips_trace_pkg::DEFAULT_CNT_W) ();
    logic             cap_en;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      alu_result;
    logic             reg_write;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_result;
    logic             out_wr;
    logic [CNT_W-1:0] out_seq;

    modport master (
        output cap_en, pc, instr, alu_result, reg_write, out_ready,
        input  out_valid, out_pc, out_instr, out_result, out_wr, out_seq
    );
    modport slave (
        input  cap_en, pc, instr, alu_result, reg_write, out_ready,
        output out_valid, out_pc, out_instr, out_result, out_wr, out_seq
    );
endinterface

// File: rtl/trace_fifo_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t rdata_o
);
    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with sequence tagging and sticky drop accounting.
// Define TRACE_FILTER_EN to capture only instructions with reg_write=1.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,  // power of two, >= 2
    parameter  int CNT_W = DEFAULT_CNT_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    trace_fifo_if.slave      bus,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] seq_q, seq_d, drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             attempt, pop, full, push, drop;
    trace_entry_t     wr_entry, rd_entry;

`ifdef TRACE_FILTER_EN
    assign attempt = bus.cap_en & bus.reg_write;
`else
    assign attempt = bus.cap_en;
`endif

    assign full = (count_q == CW'(DEPTH));
    assign pop  = bus.out_valid & bus.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push = attempt & (~full | pop);
    assign drop = attempt & full & ~pop;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            seq_d   = '0;
            drop_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (attempt) seq_d = seq_q + CNT_W'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = bus.pc;
        wr_entry.instr  = bus.instr;
        wr_entry.result = bus.alu_result;
        wr_entry.wr     = bus.reg_write;
        wr_entry.seq    = SEQ_MAX_W'(seq_q);
    end

    trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (push & ~clr),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (rd_entry)
    );

    // Upper seq bits beyond CNT_W are always zero in storage.
    logic unused_seq;
    assign unused_seq = ^rd_entry.seq;

    assign bus.out_valid  = (count_q != '0);
    assign bus.out_pc     = rd_entry.pc;
    assign bus.out_instr  = rd_entry.instr;
    assign bus.out_result = rd_entry.result;
    assign bus.out_wr     = rd_entry.wr;
    assign bus.out_seq    = rd_entry.seq[CNT_W-1:0];

    assign count    = count_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_trace_fifo.sv
// Directed bench for trace_fifo: capture, overflow, full-with-pop, filter, async reset and clear.
module tb_trace_fifo;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [3:0]       count;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    int               n_cmp = 0;
    int               n_err = 0;

    trace_fifo_if #(.CNT_W(CNT_W)) bus ();

    trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [31:0] p, input logic w);
        bus.cap_en     = 1'b1;
        bus.pc         = p;
        bus.instr      = p ^ 32'hdead_beef;
        bus.alu_result = p + 32'd1;
        bus.reg_write  = w;
        tick();
        bus.cap_en     = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

`ifdef TRACE_FILTER_EN
    localparam int FN = 2;
    logic [31:0] f_pc  [3] = '{32'h10, 32'h18, 32'h0};
    logic        f_wr  [3] = '{1'b1, 1'b1, 1'b0};
`else
    localparam int FN = 3;
    logic [31:0] f_pc  [3] = '{32'h10, 32'h14, 32'h18};
    logic        f_wr  [3] = '{1'b1, 1'b0, 1'b1};
`endif

    initial begin
        bus.cap_en = 1'b0; bus.pc = '0; bus.instr = '0; bus.alu_result = '0;
        bus.reg_write = 1'b1; bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Three captures, no drain
        for (int i = 0; i < 3; i++) capture(32'(4 * i), 1'b1);
        chk("cap3_count", count, 3);
        chk("cap3_pc", bus.out_pc, 32'h0);
        chk("cap3_seq", bus.out_seq, 0);
        chk("cap3_instr", bus.out_instr, 32'hdead_beef);
        chk("cap3_result", bus.out_result, 32'h1);

        // Seven more: ten attempts into eight slots
        for (int i = 3; i < 10; i++) capture(32'(4 * i), 1'b1);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_seq%0d", i), bus.out_seq, i);
            chk($sformatf("drain_pc%0d", i), bus.out_pc, 4 * i);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drained_valid", bus.out_valid, 0);
        chk("drained_count", count, 0);
        chk("drained_ovf_sticky", overflow, 1);

        // Full FIFO with simultaneous pop and attempt
        do_clr();
        for (int i = 0; i < 8; i++) capture(32'h100 + 32'(i), 1'b1);
        chk("full_count", count, 8);
        bus.out_ready = 1'b1;
        capture(32'h200, 1'b1);
        chk("fullpop_count", count, 8);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_drop", drop_cnt, 0);
        chk("fullpop_head", bus.out_seq, 1);
        for (int i = 1; i < 8; i++) tick();
        chk("fullpop_last_seq", bus.out_seq, 8);
        chk("fullpop_last_pc", bus.out_pc, 32'h200);
        tick();
        bus.out_ready = 1'b0;
        chk("fullpop_empty", count, 0);

        // reg_write pattern 1,0,1
        do_clr();
        capture(32'h10, 1'b1);
        capture(32'h14, 1'b0);
        capture(32'h18, 1'b1);
        chk("filt_count", count, FN);
        bus.out_ready = 1'b1;
        for (int i = 0; i < FN; i++) begin
            chk($sformatf("filt_seq%0d", i), bus.out_seq, i);
            chk($sformatf("filt_pc%0d", i), bus.out_pc, f_pc[i]);
            chk($sformatf("filt_wr%0d", i), bus.out_wr, f_wr[i]);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("filt_empty", bus.out_valid, 0);

        // Async reset mid-stream
        do_clr();
        for (int i = 0; i < 5; i++) capture(32'h40 + 32'(i), 1'b1);
        chk("pre_rst_count", count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_count", count, 0);
        #2 rst_n = 1'b1;
        capture(32'h300, 1'b1);
        chk("post_rst_count", count, 1);
        chk("post_rst_seq", bus.out_seq, 0);
        chk("post_rst_pc", bus.out_pc, 32'h300);

        // Clear with overflow set and an attempt on the same edge
        do_clr();
        for (int i = 0; i < 9; i++) capture(32'h500 + 32'(i), 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        chk("preclr_count", count, 4);
        chk("preclr_ovf", overflow, 1);
        chk("preclr_drop", drop_cnt, 1);
        clr = 1'b1; bus.cap_en = 1'b1; bus.out_ready = 1'b1; bus.pc = 32'h600;
        tick();
        clr = 1'b0; bus.cap_en = 1'b0; bus.out_ready = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_valid", bus.out_valid, 0);
        capture(32'h700, 1'b1);
        chk("clr_next_seq", bus.out_seq, 0);
        chk("clr_next_pc", bus.out_pc, 32'h700);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
